uart_hash_cmd_ctrl: RTL and testbench

//  Parametrised UART command/response controller between byte-level UART RX/TX cores and a hash core.

---
 rtl/uart_hash_cmd_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_uart_hash_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hash_cmd_ctrl.sv
// UART command/response controller in front of a hash core: length-prefixed frames in, status + digest out.
// Optional macro UART_HASH_HEX_OUT_EN sends the digest as lowercase ASCII hex instead of raw bytes.
module uart_hash_cmd_ctrl #(
  parameter int          DIGEST_W    = 256,
  parameter int          MAX_LEN     = 1024,
  parameter int          TIMEOUT_CYC = 2500000,
  parameter logic [7:0]  CMD_HASH    = 8'h01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic                hash_start,
  output logic [7:0]          hash_data,
  output logic                hash_valid,
  output logic                hash_last,
  output logic                hash_abort,
  input  logic [DIGEST_W-1:0] hash_out,
  input  logic                hash_done,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, START, PAYLOAD, WAIT_HASH, TX_ISSUE, TX_WAIT
  } state_t;

  localparam logic [7:0]  ST_ACK     = 8'h06;
  localparam logic [7:0]  ST_TOO_BIG = 8'h15;
  localparam logic [7:0]  ST_TIMEOUT = 8'h18;
  localparam logic [15:0] MAX_LEN16  = 16'(MAX_LEN);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYC - 1);
  localparam int          IDX_W      = $clog2(DIGEST_W/4) + 1;

`ifdef UART_HASH_HEX_OUT_EN
  localparam int NCHARS = DIGEST_W/4;
  localparam int SHIFT  = 4;
`else
  localparam int NCHARS = DIGEST_W/8;
  localparam int SHIFT  = 8;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_idx_q, last_idx_d;
  logic [7:0]          status_q, status_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                seen_busy_q, seen_busy_d;
  logic                started_q, started_d;
  logic [7:0]          tx_data_d, hash_data_d;
  logic                tx_start_d, hash_start_d, hash_valid_d, hash_last_d, hash_abort_d;
  logic                timed, expired, timeout;
  logic [7:0]          digest_byte;

`ifdef UART_HASH_HEX_OUT_EN
  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction
  assign digest_byte = to_hex(digest_q[DIGEST_W-1 -: 4]);
`else
  assign digest_byte = digest_q[DIGEST_W-1 -: 8];
`endif

  assign busy    = (state_q != IDLE);
  assign timed   = state_q inside {LEN_HI, LEN_LO, START, PAYLOAD, WAIT_HASH};
  assign expired = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    status_d     = status_q;
    digest_d     = digest_q;
    seen_busy_d  = seen_busy_q;
    started_d    = started_q;
    tx_data_d    = tx_data;
    hash_data_d  = hash_data;
    tx_start_d   = 1'b0;
    hash_start_d = 1'b0;
    hash_valid_d = 1'b0;
    hash_last_d  = 1'b0;
    hash_abort_d = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        started_d = 1'b0;
        if (rx_valid && rx_data == CMD_HASH) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = LEN_LO;
        end else timeout = expired;
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          if ({len_q[15:8], rx_data} > MAX_LEN16) begin
            status_d   = ST_TOO_BIG;
            idx_d      = '0;
            last_idx_d = '0;
            state_d    = TX_ISSUE;
          end else begin
            hash_start_d = 1'b1;
            started_d    = 1'b1;
            cnt_d        = '0;
            state_d      = START;
          end
        end else timeout = expired;
      end
      START: begin
        // An empty message is closed by a lone hash_last right after hash_start.
        if (len_q == 16'd0) begin
          hash_last_d = 1'b1;
          state_d     = WAIT_HASH;
        end else state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (rx_valid) begin
          hash_data_d  = rx_data;
          hash_valid_d = 1'b1;
          cnt_d        = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == len_q) begin
            hash_last_d = 1'b1;
            state_d     = WAIT_HASH;
          end
        end else timeout = expired;
      end
      WAIT_HASH: begin
        if (hash_done) begin
          digest_d   = hash_out;
          status_d   = ST_ACK;
          idx_d      = '0;
          last_idx_d = IDX_W'(NCHARS);
          state_d    = TX_ISSUE;
        end else if (!rx_valid) timeout = expired;
      end
      TX_ISSUE: begin
        if (!tx_busy) begin
          tx_data_d   = (idx_q == '0) ? status_q : digest_byte;
          tx_start_d  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // Advance only after the TX core has visibly taken and finished the byte.
        if (!seen_busy_q) begin
          if (tx_busy) seen_busy_d = 1'b1;
        end else if (!tx_busy) begin
          if (idx_q == last_idx_q) state_d = IDLE;
          else begin
            if (idx_q != '0) digest_d = digest_q << SHIFT;
            idx_d   = idx_q + IDX_W'(1);
            state_d = TX_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      hash_abort_d = started_q;
      status_d     = ST_TIMEOUT;
      idx_d        = '0;
      last_idx_d   = '0;
      state_d      = TX_ISSUE;
    end
    to_cnt_d = (rx_valid || !timed || state_d != state_q) ? 32'd0 : to_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      status_q    <= '0;
      digest_q    <= '0;
      seen_busy_q <= 1'b0;
      started_q   <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      hash_start  <= 1'b0;
      hash_data   <= '0;
      hash_valid  <= 1'b0;
      hash_last   <= 1'b0;
      hash_abort  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      status_q    <= status_d;
      digest_q    <= digest_d;
      seen_busy_q <= seen_busy_d;
      started_q   <= started_d;
      tx_data     <= tx_data_d;
      tx_start    <= tx_start_d;
      hash_start  <= hash_start_d;
      hash_data   <= hash_data_d;
      hash_valid  <= hash_valid_d;
      hash_last   <= hash_last_d;
      hash_abort  <= hash_abort_d;
    end
  end

endmodule

// File: tb/tb_uart_hash_cmd_ctrl.sv
// Directed bench for uart_hash_cmd_ctrl: byte-level UART TX model, behavioural 64-cycle hash model,
// expected-byte scoreboard. Digest expectations follow UART_HASH_HEX_OUT_EN when it is defined.
module tb_uart_hash_cmd_ctrl;
  localparam int DW  = 256;
  localparam int TO  = 300;
  localparam int LAT = 64;
  localparam logic [DW-1:0] SHA_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [DW-1:0] SHA_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          hash_start, hash_valid, hash_last, hash_abort, busy;
  logic [7:0]    hash_data;
  logic [DW-1:0] hash_out;
  logic          hash_done;

  int checks = 0;
  int errors = 0;

  uart_hash_cmd_ctrl #(.DIGEST_W(DW), .MAX_LEN(1024), .TIMEOUT_CYC(TO), .CMD_HASH(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .hash_start(hash_start), .hash_data(hash_data), .hash_valid(hash_valid),
    .hash_last(hash_last), .hash_abort(hash_abort), .hash_out(hash_out),
    .hash_done(hash_done), .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] digest_of(input logic [7:0] m[$]);
    logic [31:0] h;
    if (m.size() == 0) return SHA_EMPTY;
    if (m.size() == 3 && m[0] == 8'h61 && m[1] == 8'h62 && m[2] == 8'h63) return SHA_ABC;
    h = 32'h811c9dc5;
    foreach (m[i]) h = (h ^ {24'h0, m[i]}) * 32'h01000193;
    return {8{h}};
  endfunction

  // behavioural hash core
  logic [7:0] msg_q[$];
  int hs_cnt = 0, hv_cnt = 0, hl_cnt = 0, hl_alone_cnt = 0, abort_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  initial begin : hash_model
    int lat;
    bit pending;
    hash_done = 1'b0;
    hash_out  = '0;
    pending   = 1'b0;
    lat       = 0;
    forever begin
      @(negedge clk);
      hash_done = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        msg_q.delete();
      end else begin
        if (hash_start) begin hs_cnt++; msg_q.delete(); pending = 1'b0; end
        if (hash_abort) begin abort_cnt++; msg_q.delete(); pending = 1'b0; end
        if (hash_valid) begin hv_cnt++; msg_q.push_back(hash_data); end
        if (hash_last) begin
          hl_cnt++;
          if (!hash_valid) hl_alone_cnt++;
          else last_byte = hash_data;
          pending = 1'b1;
          lat     = LAT;
        end else if (pending) begin
          lat--;
          if (lat == 0) begin
            hash_done = 1'b1;
            hash_out  = digest_of(msg_q);
            pending   = 1'b0;
          end
        end
      end
    end
  end

  // UART TX core model: 6-cycle busy per byte
  logic [7:0] act_q[$];
  int overlap_cnt = 0;
  initial begin : tx_model
    int left;
    tx_busy = 1'b0;
    left    = 0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (tx_busy) overlap_cnt++;
        act_q.push_back(tx_data);
        tx_busy = 1'b1;
        left    = 6;
      end else if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int rd_ptr = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic exp_digest(input logic [DW-1:0] d);
    string hx;
    hx = "0123456789abcdef";
`ifdef UART_HASH_HEX_OUT_EN
    for (int i = 0; i < DW/4; i++) exp_q.push_back(hx[d[DW-1-4*i -: 4]]);
`else
    for (int i = 0; i < DW/8; i++) exp_q.push_back(d[DW-1-8*i -: 8]);
`endif
  endtask

  task automatic check_response(input string tag, input int budget);
    int n;
    n = 0;
    while (!(act_q.size() >= rd_ptr + exp_q.size() && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, DW'(n < budget), DW'(1));
    check({tag, "_byte_count"}, DW'(act_q.size() - rd_ptr), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (rd_ptr + i < act_q.size())
        check($sformatf("%s_byte%0d", tag, i), DW'(act_q[rd_ptr + i]), DW'(exp_q[i]));
    rd_ptr = act_q.size();
    exp_q.delete();
  endtask

  initial begin : main
    int hs0, hv0, hl0, ha0, ab0, n;
    logic [7:0] m5[$];

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_tx_start", DW'(tx_start), DW'(0));
    check("rst_hash_start", DW'(hash_start), DW'(0));
    check("rst_hash_valid", DW'(hash_valid), DW'(0));
    check("rst_hash_abort", DW'(hash_abort), DW'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // stray byte in IDLE is ignored
    send_byte(8'h55);
    check("idle_ignore_busy", DW'(busy), DW'(0));

    // 1: "abc"
    hs0 = hs_cnt; hv0 = hv_cnt; hl0 = hl_cnt; ha0 = hl_alone_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    exp_q.push_back(8'h06);
    exp_digest(SHA_ABC);
    check_response("abc", 3000);
    check("abc_hash_start", DW'(hs_cnt - hs0), DW'(1));
    check("abc_hash_valid", DW'(hv_cnt - hv0), DW'(3));
    check("abc_hash_last", DW'(hl_cnt - hl0), DW'(1));
    check("abc_last_byte", DW'(last_byte), DW'(8'h63));
    check("abc_last_alone", DW'(hl_alone_cnt - ha0), DW'(0));

    // 2: empty frame
    hv0 = hv_cnt; ha0 = hl_alone_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    exp_q.push_back(8'h06);
    exp_digest(SHA_EMPTY);
    check_response("empty", 3000);
    check("empty_last_alone", DW'(hl_alone_cnt - ha0), DW'(1));
    check("empty_hash_valid", DW'(hv_cnt - hv0), DW'(0));

    // 3: LEN = 1025 exceeds MAX_LEN
    hs0 = hs_cnt;
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h01);
    exp_q.push_back(8'h15);
    check_response("too_big", 500);
    check("too_big_no_start", DW'(hs_cnt - hs0), DW'(0));
    check("too_big_busy", DW'(busy), DW'(0));

    // 4: payload stalls after 2 of 4 bytes
    ab0 = abort_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    exp_q.push_back(8'h18);
    check_response("timeout", TO + 500);
    check("timeout_abort", DW'(abort_cnt - ab0), DW'(1));
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    exp_q.push_back(8'h06);
    exp_digest(SHA_ABC);
    check_response("after_timeout", 3000);

    // 5: payload containing CMD_HASH and 0xFF
    hs0 = hs_cnt; hv0 = hv_cnt;
    m5 = '{8'hFF, 8'h01, 8'hFF};
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hFF); send_byte(8'h01); send_byte(8'hFF);
    exp_q.push_back(8'h06);
    exp_digest(digest_of(m5));
    check_response("binary", 3000);
    check("binary_one_start", DW'(hs_cnt - hs0), DW'(1));
    check("binary_hash_valid", DW'(hv_cnt - hv0), DW'(3));

    // 6: reset during digest transmission
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    n = 0;
    while (act_q.size() < rd_ptr + 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_tx_reached", DW'(n < 3000), DW'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", DW'(tx_start), DW'(0));
    check("mid_rst_busy", DW'(busy), DW'(0));
    repeat (3) @(negedge clk);
    check("mid_rst_busy_held", DW'(busy), DW'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rd_ptr = act_q.size();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    exp_q.push_back(8'h06);
    exp_digest(SHA_ABC);
    check_response("after_reset", 3000);

    check("tx_overlap", DW'(overlap_cnt), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
